register_writer: RTL
====================

REGISTER_WRITER -- requirements
Module: register_writer

Interface
REQ-001 The block SHALL have one clock and synchronous, active-high reset: clk and rst, sampled on the rising edge of clk only.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 wr_valid  input  1  write request present.
REQ-005 wr_ready  output  1  block can accept a request this cycle.
REQ-006 wr_select  input  4  operation code (see REQ-013).
REQ-007 wr_data  input  8  data or target address for the operation.
REQ-008 pc_inc  input  1  advance eip by one.
REQ-009 eip, ebp, esp  output  8 each  architectural register values, driven directly from flops.
REQ-010 mem_addr  output  8  stack memory address.
REQ-011 mem_wdata  output  8  stack write data; mem_we  output  1  write strobe; mem_re  output  1  read strobe.
REQ-012 mem_rdata  input  8  stack read data, valid exactly one cycle after mem_re.

Function
REQ-013 wr_select codes SHALL be: 1 write eip; 2 write ebp; 3 no register write (immediate slot, accepted and discarded); 4 write esp; 5 push wr_data; 6 pop into ebp; 7 call (push eip, then eip <= wr_data); 8 ret (pop into eip); all other codes accepted with no effect.
REQ-014 A request SHALL be accepted on a cycle with wr_valid=1 and wr_ready=1; wr_ready SHALL be 1 only in state IDLE.
REQ-015 States SHALL be IDLE, PUSH_WR, POP_RD, POP_CAP.
REQ-016 Codes 1-4 and others SHALL complete in IDLE in the accept cycle; the register update is visible the following cycle; the state stays IDLE.
REQ-017 Push and call SHALL do the following: accept cycle esp <= esp-1, latch the data (wr_data for push, current eip for call), latch the call target, then go to PUSH_WR.
REQ-018 In PUSH_WR the block SHALL drive mem_we=1, mem_addr=esp, and mem_wdata=latched data for one cycle. For call it SHALL also load eip <= latched target. It SHALL then return to IDLE.
REQ-019 Pop and ret SHALL do the following: accept cycle go to POP_RD; in POP_RD drive mem_re=1 and mem_addr=esp for one cycle; then POP_CAP.
REQ-020 In POP_CAP the block SHALL load the target (ebp for pop, eip for ret) from mem_rdata and set esp <= esp+1, then return to IDLE.
REQ-021 Push/call latency SHALL be 2 cycles from accept to IDLE, and pop/ret latency SHALL be 3 cycles.
REQ-022 esp, eip and ebp arithmetic SHALL be modulo 256: push from esp=8'h00 writes address 8'hFF, and pop from esp=8'hFF leaves esp=8'h00.
REQ-023 pc_inc SHALL increment eip only in IDLE. It SHALL be ignored when, in the same cycle, an accepted request writes eip (code 1). It SHALL also be ignored in any non-IDLE state.
REQ-024 mem_we and mem_re SHALL never both be 1. Both SHALL be 0 in IDLE and POP_CAP. mem_addr and mem_wdata SHALL be 8'h00 whenever the corresponding strobe is 0.
REQ-025 wr_data and wr_select SHALL be ignored when not accepted; changes to them during PUSH_WR, POP_RD or POP_CAP SHALL have no effect.

Reset
REQ-026 On rst=1 the block SHALL set the following: state IDLE, eip=8'h00, ebp=8'h00, esp=8'h00, mem_we=0, mem_re=0, mem_addr=8'h00, mem_wdata=8'h00. wr_ready SHALL be 1 the cycle after rst deasserts.
REQ-027 rst SHALL take priority over every request and over pc_inc.
REQ-028 rst asserted in any non-IDLE state SHALL abandon the operation. In the cycle following rst, no mem_we or mem_re SHALL be issued.

Verification
REQ-029 Reset, then write esp: rst, then code 4 with data 8'h80 -> esp=8'h80 next cycle, wr_ready held at 1.
REQ-030 Push at wrap: esp=8'h00, code 5 with data 8'h5A -> next cycle mem_we=1, mem_addr=8'hFF, mem_wdata=8'h5A; then esp=8'hFF and IDLE.
REQ-031 Call then ret: eip=8'h10, esp=8'h80, code 7 with data 8'h40 -> stack write of 8'h10 at 8'h7F, eip=8'h40. Then code 8 with mem_rdata=8'h10 in POP_CAP -> eip=8'h10, esp=8'h80.
REQ-032 pc_inc conflict: in IDLE, pc_inc=1 with code 1 and data 8'h22 -> eip=8'h22, not 8'h23. pc_inc=1 during PUSH_WR -> eip unchanged.
REQ-033 Reset mid-pop: code 6 accepted, rst asserted in POP_RD -> following cycle all registers 0, mem_re=0, and ebp not loaded.
REQ-034 Backpressure: wr_valid held 1 through a push -> wr_ready=0 for 1 cycle; the second request is accepted only after the block returns to IDLE.

Source files
------------

// File: rtl/register_writer.sv
// Architectural register writer for eip/ebp/esp with a small stack engine.
// Push/call and pop/ret sequence through dedicated states to reach stack memory.
module register_writer (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [3:0] wr_select,
    input  logic [7:0] wr_data,
    input  logic       pc_inc,
    output logic [7:0] eip,
    output logic [7:0] ebp,
    output logic [7:0] esp,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_we,
    output logic       mem_re,
    input  logic [7:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PUSH_WR = 2'd1,
        POP_RD  = 2'd2,
        POP_CAP = 2'd3
    } state_t;

    state_t     state_q;
    logic [7:0] eip_q;
    logic [7:0] ebp_q;
    logic [7:0] esp_q;
    logic [7:0] target_q;
    logic       is_call_q;
    logic       is_ret_q;
    logic [7:0] mem_addr_q;
    logic [7:0] mem_wdata_q;
    logic       mem_we_q;
    logic       mem_re_q;
    logic       accept;

    assign wr_ready = (state_q == IDLE);
    assign accept   = wr_valid && wr_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            eip_q       <= '0;
            ebp_q       <= '0;
            esp_q       <= '0;
            target_q    <= '0;
            is_call_q   <= 1'b0;
            is_ret_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
        end else begin
            // Strobes are one-cycle pulses; address/data fall back to zero with them.
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            case (state_q)
                IDLE: begin
                    if (pc_inc && !(accept && wr_select == 4'd1))
                        eip_q <= eip_q + 8'd1;
                    if (accept) begin
                        case (wr_select)
                            4'd1: eip_q <= wr_data;
                            4'd2: ebp_q <= wr_data;
                            4'd4: esp_q <= wr_data;
                            4'd5, 4'd7: begin
                                // Strobe is registered here so it lines up with PUSH_WR.
                                esp_q       <= esp_q - 8'd1;
                                mem_addr_q  <= esp_q - 8'd1;
                                mem_wdata_q <= (wr_select == 4'd7) ? eip_q : wr_data;
                                mem_we_q    <= 1'b1;
                                target_q    <= wr_data;
                                is_call_q   <= (wr_select == 4'd7);
                                state_q     <= PUSH_WR;
                            end
                            4'd6, 4'd8: begin
                                mem_addr_q <= esp_q;
                                mem_re_q   <= 1'b1;
                                is_ret_q   <= (wr_select == 4'd8);
                                state_q    <= POP_RD;
                            end
                            default: ;
                        endcase
                    end
                end
                PUSH_WR: begin
                    if (is_call_q)
                        eip_q <= target_q;
                    state_q <= IDLE;
                end
                POP_RD: begin
                    state_q <= POP_CAP;
                end
                POP_CAP: begin
                    if (is_ret_q)
                        eip_q <= mem_rdata;
                    else
                        ebp_q <= mem_rdata;
                    esp_q   <= esp_q + 8'd1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign eip       = eip_q;
    assign ebp       = ebp_q;
    assign esp       = esp_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;

endmodule
